// File: rtl/fpu_mul_seq.sv
// Iterative IEEE-754 single multiplier: radix-2 shift-add significand product, normalized, unrounded.
// Latency 26 clocks (2 for a zero operand); ready held in DONE until en drops, en ignored while busy.
module fpu_mul_seq #(
    parameter int                          OPERAND_WIDTH     = 32,
    parameter int                          EXPONENT_WIDTH    = 8,
    parameter int                          FRACTION_WIDTH    = 23,
    parameter int                          SIGNIFICAND_WIDTH = FRACTION_WIDTH + 1,
    parameter logic [EXPONENT_WIDTH-1:0]   BIASING_CONSTANT  = 8'b0111_1111
) (
    input  logic                        fpu_clk,
    input  logic                        fpu_rst_n,
    input  logic                        fmul_en_i,
    input  logic [OPERAND_WIDTH-1:0]    fmul_op_a_i,
    input  logic [OPERAND_WIDTH-1:0]    fmul_op_b_i,
    output logic                        fmul_ready_o,
    output logic                        fmuldiv_sign_o,
    output logic [EXPONENT_WIDTH-1:0]   fmuldiv_biased_exp_o,
    output logic [FRACTION_WIDTH-1:0]   fmuldiv_frac_o,
    output logic [2:0]                  fmuldiv_grs_o,
    output logic                        fmuldiv_exp_ovf_o,
    output logic                        fmuldiv_exp_uf_o
);

    localparam int SW = SIGNIFICAND_WIDTH;
    localparam int PW = 2 * SIGNIFICAND_WIDTH;
    localparam int XW = EXPONENT_WIDTH + 2;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXPONENT_WIDTH) - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state;
    logic [4:0]            cnt;
    logic [SW-1:0]         mcand;
    logic [PW-1:0]         prod;
    logic                  sign_q;
    logic                  zero_flag;
    logic signed [XW-1:0]  exp_sum;

    logic [EXPONENT_WIDTH-1:0] ea, eb;
    logic [FRACTION_WIDTH-1:0] fa, fb;
    logic signed [XW-1:0]      exp_sum_n;

    assign ea = fmul_op_a_i[OPERAND_WIDTH-2 -: EXPONENT_WIDTH];
    assign eb = fmul_op_b_i[OPERAND_WIDTH-2 -: EXPONENT_WIDTH];
    assign fa = fmul_op_a_i[FRACTION_WIDTH-1:0];
    assign fb = fmul_op_b_i[FRACTION_WIDTH-1:0];
    assign exp_sum_n = $signed({2'b00, ea}) + $signed({2'b00, eb})
                     - $signed({2'b00, BIASING_CONSTANT});

    // Upper half accumulates; multiplier bits drain out of the lower half as the product shifts in.
    logic [SW:0]   add_sum;
    logic [PW-1:0] prod_next;

    always_comb begin
        add_sum   = {1'b0, prod[PW-1:SW]} + (prod[0] ? {1'b0, mcand} : {(SW+1){1'b0}});
        prod_next = {add_sum, prod[SW-1:1]};
    end

    logic signed [XW-1:0]      exp_fin;
    logic [FRACTION_WIDTH-1:0] frac_n;
    logic [2:0]                grs_n;
    logic                      ovf_n, uf_n;

    always_comb begin
        if (prod[PW-1]) begin
            exp_fin = exp_sum + XW'(1);
            frac_n  = prod[PW-2 -: FRACTION_WIDTH];
            grs_n   = {prod[SW-1], prod[SW-2], |prod[SW-3:0]};
        end else begin
            exp_fin = exp_sum;
            frac_n  = prod[PW-3 -: FRACTION_WIDTH];
            grs_n   = {prod[SW-2], prod[SW-3], |prod[SW-4:0]};
        end
        ovf_n = (exp_fin >= EXP_MAX);
        uf_n  = (exp_fin <= XW'(0));
    end

    assign fmul_ready_o = (state == S_DONE);

    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            mcand                <= '0;
            prod                 <= '0;
            sign_q               <= 1'b0;
            zero_flag            <= 1'b0;
            exp_sum              <= '0;
            fmuldiv_sign_o       <= 1'b0;
            fmuldiv_biased_exp_o <= '0;
            fmuldiv_frac_o       <= '0;
            fmuldiv_grs_o        <= '0;
            fmuldiv_exp_ovf_o    <= 1'b0;
            fmuldiv_exp_uf_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fmul_en_i) begin
                        sign_q               <= fmul_op_a_i[OPERAND_WIDTH-1] ^ fmul_op_b_i[OPERAND_WIDTH-1];
                        exp_sum              <= exp_sum_n;
                        mcand                <= {1'b1, fa};
                        prod                 <= {{SW{1'b0}}, 1'b1, fb};
                        cnt                  <= '0;
                        fmuldiv_sign_o       <= 1'b0;
                        fmuldiv_biased_exp_o <= '0;
                        fmuldiv_frac_o       <= '0;
                        fmuldiv_grs_o        <= '0;
                        fmuldiv_exp_ovf_o    <= 1'b0;
                        fmuldiv_exp_uf_o     <= 1'b0;
                        // Denormals are treated as zero: no hidden bit to multiply.
                        if (ea == '0 || eb == '0) begin
                            zero_flag <= 1'b1;
                            state     <= S_NORM;
                        end else begin
                            zero_flag <= 1'b0;
                            state     <= S_MULT;
                        end
                    end
                end
                S_MULT: begin
                    prod <= prod_next;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'(SW - 1)) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    fmuldiv_sign_o <= sign_q;
                    if (zero_flag || uf_n) begin
                        fmuldiv_biased_exp_o <= '0;
                        fmuldiv_frac_o       <= '0;
                        fmuldiv_grs_o        <= '0;
                        fmuldiv_exp_ovf_o    <= 1'b0;
                        fmuldiv_exp_uf_o     <= !zero_flag;
                    end else if (ovf_n) begin
                        fmuldiv_biased_exp_o <= '1;
                        fmuldiv_frac_o       <= '0;
                        fmuldiv_grs_o        <= '0;
                        fmuldiv_exp_ovf_o    <= 1'b1;
                        fmuldiv_exp_uf_o     <= 1'b0;
                    end else begin
                        fmuldiv_biased_exp_o <= exp_fin[EXPONENT_WIDTH-1:0];
                        fmuldiv_frac_o       <= frac_n;
                        fmuldiv_grs_o        <= grs_n;
                        fmuldiv_exp_ovf_o    <= 1'b0;
                        fmuldiv_exp_uf_o     <= 1'b0;
                    end
                    state <= S_DONE;
                end
                default: begin
                    if (!fmul_en_i) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed bench for fpu_mul_seq: hand-computed products, latency, flags, reset and en handshake.
module tb_fpu_mul_seq;

    logic        fpu_clk = 1'b0;
    logic        fpu_rst_n = 1'b0;
    logic        fmul_en_i = 1'b0;
    logic [31:0] fmul_op_a_i = '0;
    logic [31:0] fmul_op_b_i = '0;
    logic        fmul_ready_o;
    logic        fmuldiv_sign_o;
    logic [7:0]  fmuldiv_biased_exp_o;
    logic [22:0] fmuldiv_frac_o;
    logic [2:0]  fmuldiv_grs_o;
    logic        fmuldiv_exp_ovf_o;
    logic        fmuldiv_exp_uf_o;

    int errors = 0;
    int checks = 0;

    // Edges after the sampling edge until ready is seen (26 / 2 clocks counting the sampling edge).
    localparam int LAT_NORMAL = 25;
    localparam int LAT_ZERO   = 1;

    fpu_mul_seq dut (
        .fpu_clk              (fpu_clk),
        .fpu_rst_n            (fpu_rst_n),
        .fmul_en_i            (fmul_en_i),
        .fmul_op_a_i          (fmul_op_a_i),
        .fmul_op_b_i          (fmul_op_b_i),
        .fmul_ready_o         (fmul_ready_o),
        .fmuldiv_sign_o       (fmuldiv_sign_o),
        .fmuldiv_biased_exp_o (fmuldiv_biased_exp_o),
        .fmuldiv_frac_o       (fmuldiv_frac_o),
        .fmuldiv_grs_o        (fmuldiv_grs_o),
        .fmuldiv_exp_ovf_o    (fmuldiv_exp_ovf_o),
        .fmuldiv_exp_uf_o     (fmuldiv_exp_uf_o)
    );

    always #5 fpu_clk = ~fpu_clk;

    // {sign, exp, frac, grs, ovf, uf}
    wire [36:0] res = {fmuldiv_sign_o, fmuldiv_biased_exp_o, fmuldiv_frac_o,
                       fmuldiv_grs_o, fmuldiv_exp_ovf_o, fmuldiv_exp_uf_o};

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold_en,
                         output int lat, output logic [36:0] start_snap);
        @(negedge fpu_clk);
        fmul_op_a_i = a;
        fmul_op_b_i = b;
        fmul_en_i   = 1'b1;
        @(posedge fpu_clk);
        #1;
        start_snap = res;
        if (!hold_en) fmul_en_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge fpu_clk);
            @(negedge fpu_clk);
            if (fmul_ready_o) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (fmul_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", fmul_ready_o);
        end
        checks++;
        if (res !== 37'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", res);
        end
        @(negedge fpu_clk);
        fpu_rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat; logic [36:0] snap;
        do_op(32'h3FC00000, 32'h40000000, 1'b0, lat, snap);
        checks++;
        if (lat !== LAT_NORMAL) begin
            errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT_NORMAL);
        end
        checks++;
        if (res !== {1'b0, 8'h80, 23'h400000, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL basic_result got=%h", res);
        end
    endtask

    task automatic test_norm_carry;
        int lat; logic [36:0] snap;
        do_op(32'h3FC00000, 32'h3FC00000, 1'b0, lat, snap);
        checks++;
        if (snap !== 37'd0) begin
            errors++; $display("FAIL carry_clear_on_start got=%h exp=0", snap);
        end
        checks++;
        if (res !== {1'b0, 8'h80, 23'h100000, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL carry_result got=%h", res);
        end
    endtask

    task automatic test_sticky;
        int lat; logic [36:0] snap;
        do_op(32'hBF800001, 32'h3F800001, 1'b0, lat, snap);
        checks++;
        if (lat !== LAT_NORMAL) begin
            errors++; $display("FAIL sticky_latency got=%0d exp=%0d", lat, LAT_NORMAL);
        end
        checks++;
        if (res !== {1'b1, 8'h7F, 23'h000002, 3'b001, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sticky_result got=%h", res);
        end
    endtask

    task automatic test_exp_bounds;
        int lat; logic [36:0] snap;
        do_op(32'h7F000000, 32'h7F000000, 1'b0, lat, snap);
        checks++;
        if (res !== {1'b0, 8'hFF, 23'h0, 3'b000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL overflow_result got=%h", res);
        end
        do_op(32'h00800000, 32'h3F000000, 1'b0, lat, snap);
        checks++;
        if (lat !== LAT_NORMAL) begin
            errors++; $display("FAIL underflow_latency got=%0d exp=%0d", lat, LAT_NORMAL);
        end
        checks++;
        if (res !== {1'b0, 8'h00, 23'h0, 3'b000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL underflow_result got=%h", res);
        end
    endtask

    task automatic test_zero;
        int lat; logic [36:0] snap;
        do_op(32'h00000000, 32'h40490FDB, 1'b0, lat, snap);
        checks++;
        if (lat !== LAT_ZERO) begin
            errors++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT_ZERO);
        end
        checks++;
        if (res !== 37'd0) begin
            errors++; $display("FAIL zero_result got=%h exp=0", res);
        end
        // Sign survives the zero path.
        do_op(32'h80000000, 32'h3F800000, 1'b0, lat, snap);
        checks++;
        if (res !== {1'b1, 36'd0}) begin
            errors++; $display("FAIL zero_sign got=%h", res);
        end
    endtask

    task automatic test_reset_in_done;
        int lat; logic [36:0] snap;
        do_op(32'h3FC00000, 32'h3FC00000, 1'b1, lat, snap);
        #2;
        fpu_rst_n = 1'b0;
        #1;
        checks++;
        if (fmul_ready_o !== 1'b0) begin
            errors++; $display("FAIL done_reset_ready got=%b exp=0", fmul_ready_o);
        end
        checks++;
        if (res !== 37'd0) begin
            errors++; $display("FAIL done_reset_outputs got=%h exp=0", res);
        end
        fmul_en_i = 1'b0;
        @(negedge fpu_clk);
        fpu_rst_n = 1'b1;
    endtask

    task automatic test_reset_mid;
        int lat; logic [36:0] snap;
        @(negedge fpu_clk);
        fmul_op_a_i = 32'h3FC00000;
        fmul_op_b_i = 32'h40000000;
        fmul_en_i   = 1'b1;
        @(posedge fpu_clk);
        #1 fmul_en_i = 1'b0;
        repeat (10) @(posedge fpu_clk);
        #2;
        fpu_rst_n = 1'b0;
        #1;
        checks++;
        if ({fmul_ready_o, res} !== 38'd0) begin
            errors++; $display("FAIL mid_reset_outputs got=%h exp=0", {fmul_ready_o, res});
        end
        @(negedge fpu_clk);
        fpu_rst_n = 1'b1;
        // A fresh op must start from IDLE with full latency and a clean accumulator.
        do_op(32'hBF800001, 32'h3F800001, 1'b0, lat, snap);
        checks++;
        if (lat !== LAT_NORMAL) begin
            errors++; $display("FAIL reissue_latency got=%0d exp=%0d", lat, LAT_NORMAL);
        end
        checks++;
        if (res !== {1'b1, 8'h7F, 23'h000002, 3'b001, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reissue_result got=%h", res);
        end
    endtask

    task automatic test_hold_en;
        int lat; logic [36:0] snap;
        logic [36:0] expv;
        expv = {1'b0, 8'h80, 23'h400000, 3'b000, 1'b0, 1'b0};
        do_op(32'h3FC00000, 32'h40000000, 1'b1, lat, snap);
        checks++;
        if (lat !== LAT_NORMAL) begin
            errors++; $display("FAIL hold_latency got=%0d exp=%0d", lat, LAT_NORMAL);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge fpu_clk);
            checks++;
            if ({fmul_ready_o, res} !== {1'b1, expv}) begin
                errors++; $display("FAIL hold_done_%0d got=%h exp=%h", i, {fmul_ready_o, res}, {1'b1, expv});
            end
        end
        fmul_en_i = 1'b0;
        @(negedge fpu_clk);
        checks++;
        if (fmul_ready_o !== 1'b0) begin
            errors++; $display("FAIL hold_release_ready got=%b exp=0", fmul_ready_o);
        end
        checks++;
        if (res !== expv) begin
            errors++; $display("FAIL hold_idle_outputs got=%h exp=%h", res, expv);
        end
        @(negedge fpu_clk);
        checks++;
        if (fmul_ready_o !== 1'b0) begin
            errors++; $display("FAIL idle_stays got=%b exp=0", fmul_ready_o);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_norm_carry;
        test_sticky;
        test_exp_bounds;
        test_zero;
        test_reset_in_done;
        test_reset_mid;
        test_hold_en;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_mul_seq.md
Name: fpu_mul_seq

Overview:
Iterative single-precision multiplier that sits directly upstream of fpu_enc. It drives fpu_enc's fmuldiv_sign_i, fmuldiv_biased_exp_i, fmuldiv_frac_i, fmuldiv_grs_i and fmuldiv_exp_ovf_i inputs. It takes two IEEE-754 operands, forms the 48-bit significand product with a radix-2 shift-add loop, and normalizes it. It emits the unrounded sign, biased exponent, 23-bit fraction, guard/round/sticky bits and exponent flags; fpu_enc does all rounding and packing. NaN/Inf classification is done elsewhere (fpu_out_type), so this block treats every non-zero-exponent operand as finite normal.

Parameters:
OPERAND_WIDTH, 32, operand width
EXPONENT_WIDTH, 8, exponent field width
FRACTION_WIDTH, 23, fraction field width
SIGNIFICAND_WIDTH, FRACTION_WIDTH+1, significand width including hidden 1
BIASING_CONSTANT, 8'b0111_1111, exponent bias

Ports:
fpu_clk  in  1  clock, rising edge
fpu_rst_n  in  1  asynchronous active-low reset
fmul_en_i  in  1  start request, level; sampled only in IDLE
fmul_op_a_i  in  OPERAND_WIDTH  operand A
fmul_op_b_i  in  OPERAND_WIDTH  operand B
fmul_ready_o  out  1  result valid, high only in DONE
fmuldiv_sign_o  out  1  product sign
fmuldiv_biased_exp_o  out  EXPONENT_WIDTH  normalized biased exponent
fmuldiv_frac_o  out  FRACTION_WIDTH  normalized fraction, hidden bit dropped, unrounded
fmuldiv_grs_o  out  3  guard, round, sticky (bit2 = G)
fmuldiv_exp_ovf_o  out  1  exponent overflow
fmuldiv_exp_uf_o  out  1  exponent underflow (result flushed)

Behaviour:
- Reset (async, any state): FSM goes to IDLE, counter 0, product/multiplier registers 0. All outputs go to 0.
- States and transitions:
  - IDLE: when fmul_en_i=1 at a rising edge, latch A and B; compute sign = A[31]^B[31].
    - If either exponent field is 0 (zero or denormal, both treated as zero): next state NORM with zero_flag=1.
    - Otherwise: next state MULT.
  - MULT: 24 iterations, counter 0..23. Each cycle: if multiplier LSB=1, add multiplicand to the upper partial; then shift the 48-bit product right by 1. After counter=23, next state NORM.
  - NORM: one cycle; computes and registers outputs; next state DONE.
  - DONE: fmul_ready_o=1, outputs held stable. When fmul_en_i=0 at a rising edge, go to IDLE. ready is therefore high for at least 1 cycle and until en drops.
- Latency: ready rises 26 clocks after the sampling edge for a normal operation, 2 clocks for a zero operand.
- fmul_en_i is ignored outside IDLE; dropping it mid-operation does not abort.
- Outputs change only on the NORM->DONE edge. They clear to 0 on the IDLE->MULT/NORM edge.
- Arithmetic:
  - exp_sum = ea + eb - BIASING_CONSTANT, computed in 10-bit signed.
  - Significands: ma = {1,fa}, mb = {1,fb}; P = ma*mb (48 bits).
  - If P[47]=1: exp = exp_sum+1, frac = P[46:24], G = P[23], R = P[22], S = |P[21:0].
  - Else: exp = exp_sum, frac = P[45:23], G = P[22], R = P[21], S = |P[20:0].
- Exponent boundaries:
  - Final exp >= 255: exp_ovf=1, exp=8'hFF, frac=0, grs=0.
  - Final exp <= 0: exp_uf=1, exp=0, frac=0, grs=0 (flush; no denormal output).
  - zero_flag: exp=0, frac=0, grs=0, both flags 0, sign kept.

Test Plan:
- A=0x3FC00000, B=0x40000000 -> ready after 26 clk; sign=0, exp=0x80, frac=0x400000, grs=000, ovf=uf=0.
- A=B=0x3FC00000 (1.5*1.5, normalization carry) -> sign=0, exp=0x80, frac=0x100000, grs=000.
- A=0xBF800001, B=0x3F800001 -> sign=1, exp=0x7F, frac=0x000002, grs=001.
- A=B=0x7F000000 -> exp_ovf=1, exp=0xFF, frac=0, grs=0; then A=0x00800000, B=0x3F000000 -> exp_uf=1, exp=0, frac=0.
- A=0x00000000, B=0x40490FDB -> ready 2 clk after sampling; all fields 0, flags 0.
- Start a normal op, pulse fpu_rst_n low at MULT counter=10 -> all outputs 0 immediately, FSM in IDLE. Re-issue with en held high through DONE -> ready stays high until en drops, then IDLE one clock later.
